// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters. It issues one registered one-hot grant with its encoded
// index, and the grant is held until the holder releases it. Define ARB_TIMEOUT_EN to add a forced release after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] win;
  logic [2:0] idx;
  logic       release_w;
  logic       force_w;

  if (2**CNT_W <= MAX_HOLD) begin : g_bad_cnt_w
    $error("rr_arbiter8: CNT_W too narrow for MAX_HOLD");
  end

  // Circular search starting at ptr_q; the first set bit wins.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign release_w = done | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // The counter reads 0 on the first BUSY cycle, so it reaches MAX_HOLD-1 on the last allowed cycle.
  assign hold_cnt_d = (state_q == IDLE) ? '0 : hold_cnt_q + 1'b1;
  assign force_w    = (state_q == BUSY) && !release_w &&
                      (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign force_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d  = BUSY;
          gnt_d    = 8'b1 << win;
          gnt_id_d = win;
        end
      end
      BUSY: begin
        if (release_w || force_w) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = gnt_id_q + 3'd1;
          timeout_d = force_w;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous so the grant drops immediately, even in the middle of a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop see the values from before the edge.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8. It runs a directed vector table, hand-written corner sequences,
// and random traffic that is compared against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: the owner is picked by scanning (ptr + k) % 8 for k = 0..7.
  int         m_ptr, m_id, m_hold;
  bit         m_busy, m_to;
  logic [7:0] m_gnt;

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_hold = 0; m_busy = 0; m_to = 0; m_gnt = '0;
  endtask

  task automatic model_update();
    bit rel, forced;
    m_to = 0;
    if (!m_busy) begin
      if (en && req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_id = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1; m_hold = 0; m_gnt = 8'(1 << m_id);
      end
    end else begin
      rel    = done || !req[m_id];
      m_hold = m_hold + 1;
      forced = TO_EN && !rel && (m_hold >= MAX_HOLD);
      if (rel || forced) begin
        m_busy = 0; m_gnt = '0; m_ptr = (m_id + 1) % 8; m_to = forced;
      end
    end
  endtask

  // Inputs only change at posedge+1, so the model sees the same values the flops sampled.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_gnt;
    logic [2:0] exp_id;
    logic       exp_vld;
  } vec_t;

  vec_t vecs[$];
  int   vld_cycles;

  initial begin
    // Each row holds {en, req, done} and the expected outputs after the next edge.
    vecs = '{
      '{1'b1, 8'h14, 1'b0, 8'h04, 3'd2, 1'b1},
      '{1'b1, 8'h14, 1'b1, 8'h00, 3'd2, 1'b0},
      '{1'b1, 8'h14, 1'b0, 8'h10, 3'd4, 1'b1},
      '{1'b1, 8'h14, 1'b1, 8'h00, 3'd4, 1'b0},
      '{1'b1, 8'hFF, 1'b0, 8'h20, 3'd5, 1'b1},
      '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd5, 1'b0},
      '{1'b1, 8'hFF, 1'b0, 8'h40, 3'd6, 1'b1},
      '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd6, 1'b0},
      '{1'b1, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1},
      '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0},
      '{1'b1, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1},
      '{1'b1, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0},
      '{1'b1, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1},
      '{1'b0, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1},
      '{1'b0, 8'h08, 1'b1, 8'h00, 3'd7, 1'b0},
      '{1'b0, 8'h08, 1'b0, 8'h00, 3'd7, 1'b0},
      '{1'b0, 8'h08, 1'b0, 8'h00, 3'd7, 1'b0},
      '{1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1},
      '{1'b1, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0},
      '{1'b1, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1},
      '{1'b1, 8'h08, 1'b1, 8'h00, 3'd3, 1'b0}
    };

    do_reset();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_id", 32'(gnt_id), 32'h0);
    check("reset_vld", 32'(gnt_vld), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; req = vecs[i].req; done = vecs[i].done;
      step();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].exp_id));
      check($sformatf("vec%0d_vld", i), 32'(gnt_vld), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
    end

    // An asynchronous reset in mid-grant must clear the outputs before any clock edge.
    do_reset();
    en = 1'b1; req = 8'h40; done = 1'b0;
    step();
    check("pre_async_gnt", 32'(gnt), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_id", 32'(gnt_id), 32'h0);
    check("async_vld", 32'(gnt_vld), 32'h0);
    check("async_timeout", 32'(timeout), 32'h0);

    // A requester that never releases is held forever, or cut off after MAX_HOLD cycles in the timeout build.
    do_reset();
    en = 1'b1; req = 8'h02; done = 1'b0;
    vld_cycles = 0;
    step();
    for (int c = 0; c < 12 && gnt_vld; c++) begin
      check("hold_gnt", 32'(gnt), 32'h02);
      check("hold_timeout", 32'(timeout), 32'h0);
      vld_cycles++;
      step();
    end
`ifdef ARB_TIMEOUT_EN
    check("hold_cycles", 32'(vld_cycles), 32'(MAX_HOLD));
    check("forced_gnt", 32'(gnt), 32'h0);
    check("forced_timeout", 32'(timeout), 32'h1);
    req = 8'h06;
    step();
    check("forced_pulse_end", 32'(timeout), 32'h0);
    check("forced_ptr_id", 32'(gnt_id), 32'h2);
    check("forced_ptr_gnt", 32'(gnt), 32'h04);
`else
    check("held_cycles", 32'(vld_cycles), 32'd12);
    check("held_gnt", 32'(gnt), 32'h02);
    check("held_timeout", 32'(timeout), 32'h0);
`endif

    // Random traffic is compared cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en   = ($urandom_range(0, 7) != 0);
      req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      done = ($urandom_range(0, 3) == 0);
      step();
      check("rnd_gnt", 32'(gnt), 32'(m_gnt));
      check("rnd_id", 32'(gnt_id), 32'(m_id));
      check("rnd_vld", 32'(gnt_vld), 32'(m_gnt != 0));
      check("rnd_timeout", 32'(timeout), 32'(m_to));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
